axi_dma_sniffer: RTL and testbench

// Passive throughput monitor tapped onto an AXI-Stream/DMA data path.

---
 rtl/axi_dma_sniffer.sv | 61 ++++++
 tb/tb_axi_dma_sniffer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/axi_dma_sniffer.sv
// Passive AXI-Stream throughput monitor: counts accepted beats per 1 us window; results registered at window close.
// Latency: results update on the closing edge and hold one window; ready is !reset, so the stream is never stalled.
module axi_dma_sniffer #(
  parameter int DATA_WIDTH    = 256,
  parameter int COUNTER_WIDTH = 32,
  parameter int CLK_FREQ      = 200000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    data,
  input  logic                     valid,
  output logic                     ready,
  output logic [COUNTER_WIDTH-1:0] debug_output,
  output logic [COUNTER_WIDTH-1:0] bitrate_output,
  output logic [COUNTER_WIDTH-1:0] valid_clocks
);

  localparam int CLKS_PER_US = CLK_FREQ / 1000000;
  localparam int CYC_W       = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam int PROD_W      = COUNTER_WIDTH + $clog2(DATA_WIDTH) + 1;
  localparam logic [CYC_W-1:0]  LAST_CYC = CYC_W'(CLKS_PER_US - 1);
  localparam logic [PROD_W-1:0] SAT_MAX  = {{(PROD_W-COUNTER_WIDTH){1'b0}}, {COUNTER_WIDTH{1'b1}}};

  logic                     beat;
  logic [CYC_W-1:0]         cyc_cnt;
  logic [COUNTER_WIDTH-1:0] beat_cnt;
  logic [COUNTER_WIDTH-1:0] total;
  logic [PROD_W-1:0]        product;
  logic [COUNTER_WIDTH-1:0] bits;
  logic                     unused_data;

  // Payload is tapped for visibility only; it never feeds the arithmetic.
  assign unused_data = ^data;

  assign ready   = !reset;
  assign beat    = valid && ready;
  assign total   = beat_cnt + COUNTER_WIDTH'(beat);
  assign product = PROD_W'(total) * PROD_W'(DATA_WIDTH);
  assign bits    = (product > SAT_MAX) ? '1 : product[COUNTER_WIDTH-1:0];

  assign debug_output = beat_cnt;

  // A beat landing on the closing edge is credited to the window being closed.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt        <= '0;
      beat_cnt       <= '0;
      bitrate_output <= '0;
      valid_clocks   <= '0;
    end else if (cyc_cnt == LAST_CYC) begin
      valid_clocks   <= total;
      bitrate_output <= bits;
      beat_cnt       <= '0;
      cyc_cnt        <= '0;
    end else begin
      beat_cnt       <= total;
      cyc_cnt        <= cyc_cnt + CYC_W'(1);
    end
  end

endmodule

// File: tb/tb_axi_dma_sniffer.sv
// Randomized bench for axi_dma_sniffer: a window-queue reference model checks every cycle, plus directed scenarios.
module tb_axi_dma_sniffer;

  localparam int DW   = 256;
  localparam int CLKS = 200;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data;
  logic          valid;

  logic          ready, ready_sat;
  logic [31:0]   debug_output, bitrate_output, valid_clocks;
  logic [11:0]   debug_sat, bitrate_sat, valid_clocks_sat;

  int checks = 0;
  int errors = 0;

  // Reference model: the beats of the current window, in order.
  bit     window_q[$];
  longint exp_vc, exp_br, exp_br12;

  axi_dma_sniffer dut (
    .clk(clk), .reset(reset), .data(data), .valid(valid), .ready(ready),
    .debug_output(debug_output), .bitrate_output(bitrate_output), .valid_clocks(valid_clocks)
  );

  axi_dma_sniffer #(.COUNTER_WIDTH(12)) dut_sat (
    .clk(clk), .reset(reset), .data(data), .valid(valid), .ready(ready_sat),
    .debug_output(debug_sat), .bitrate_output(bitrate_sat), .valid_clocks(valid_clocks_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint sat(input longint x, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (x > m) ? m : x;
  endfunction

  function automatic longint window_sum();
    longint s = 0;
    foreach (window_q[i]) s += window_q[i];
    return s;
  endfunction

  // One clock: drive inputs, advance the model on the edge, compare 1 time unit later.
  task automatic step(input bit v, input bit r);
    longint live;
    valid = v;
    reset = r;
    for (int i = 0; i < DW / 32; i++) data[i*32 +: 32] = $urandom();
    @(posedge clk);
    if (r) begin
      window_q.delete();
      exp_vc = 0; exp_br = 0; exp_br12 = 0;
    end else begin
      window_q.push_back(v);
      if (window_q.size() == CLKS) begin
        exp_vc   = window_sum();
        exp_br   = sat(exp_vc * DW, 32);
        exp_br12 = sat(exp_vc * DW, 12);
        window_q.delete();
      end
    end
    #1;
    live = window_sum();
    check("ready",         ready,            !r);
    check("debug",         debug_output,     live);
    check("bitrate",       bitrate_output,   exp_br);
    check("valid_clocks",  valid_clocks,     exp_vc);
    check("ready12",       ready_sat,        !r);
    check("debug12",       debug_sat,        live);
    check("bitrate12",     bitrate_sat,      exp_br12);
    check("valid_clocks12", valid_clocks_sat, exp_vc);
  endtask

  initial begin
    int n;
    int density;
    bit v;
    reset = 1'b1;
    valid = 1'b0;
    data  = '0;
    exp_vc = 0; exp_br = 0; exp_br12 = 0;

    // Reset hold
    repeat (10) step(1'b0, 1'b1);
    check("rst_ready", ready, 1'b0);
    check("rst_bitrate", bitrate_output, 0);

    // Continuous traffic for five whole windows
    repeat (1000) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("full_bitrate", bitrate_output, 51200);
    check("full_vc", valid_clocks, 200);
    check("sat_bitrate", bitrate_sat, 4095);
    check("sat_vc", valid_clocks_sat, 200);

    // Rest of that window idle -> the close reports nothing
    repeat (CLKS - 1) step(1'b0, 1'b0);
    check("idle_bitrate", bitrate_output, 0);
    check("idle_vc", valid_clocks, 0);

    // Alternating valid, window aligned
    for (int i = 0; i < 3 * CLKS; i++) step(i % 2 == 0, 1'b0);
    check("half_bitrate", bitrate_output, 25600);
    check("half_vc", valid_clocks, 100);
    check("half_debug", debug_output, 0);

    // Reset pulse mid-window with traffic
    repeat (57) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("midrst_bitrate", bitrate_output, 0);
    check("midrst_vc", valid_clocks, 0);
    check("midrst_debug", debug_output, 0);
    n = 0;
    for (int i = 0; i < CLKS; i++) begin
      v = $urandom_range(0, 1);
      n += v;
      step(v, 1'b0);
    end
    check("postrst_vc", valid_clocks, n);
    check("postrst_bitrate", bitrate_output, n * DW);

    // Random traffic with varying density and occasional resets
    for (int blk = 0; blk < 30; blk++) begin
      density = $urandom_range(0, 100);
      for (int i = 0; i < 100; i++) begin
        v = ($urandom_range(0, 99) < density);
        step(v, $urandom_range(0, 399) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
